// File: rtl/bwt_sched.sv
// bwt_sched: shares one BWT core between two string requesters.
//
// A round-robin arbiter grants one requester. The scheduler then streams that
// requester's STRING_LEN characters into the core load port and pulses
// core_start. It collects STRING_LEN transformed characters and returns them
// to the same requester. A response watchdog aborts the transaction if the
// core stays silent for TIMEOUT consecutive cycles while a response is pending.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   req[1:0]                  per-requester service request (level)
//   gnt[1:0]                  one-hot grant, zero when idle
//   in_valid[1:0]             per-requester character valid
//   in_char0, in_char1        requester characters
//   in_ready[1:0]             load ready, only on the granted bit
//   core_wr, core_char        core load strobe / character
//   core_start                one-cycle core start pulse
//   core_valid_in, core_char_in  core output character stream
//   out_char, out_valid[1:0]  returned character and per-requester valid
//   out_last                  final returned character marker
//   err                       one-cycle watchdog abort pulse
//   busy                      high whenever the scheduler is not idle
module bwt_sched #(
  parameter int STRING_LEN = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [1:0] in_valid,
  input  logic [7:0] in_char0,
  input  logic [7:0] in_char1,
  output logic [1:0] in_ready,
  output logic       core_wr,
  output logic [7:0] core_char,
  output logic       core_start,
  input  logic       core_valid_in,
  input  logic [7:0] core_char_in,
  output logic [7:0] out_char,
  output logic [1:0] out_valid,
  output logic       out_last,
  output logic       err,
  output logic       busy
);

  localparam int LW = $clog2(STRING_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LAST_IDX = LW'(STRING_LEN - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    gnt_nxt;
  logic          last_srv, last_srv_nxt;
  logic [LW-1:0] ld_cnt, ld_cnt_nxt;
  logic [LW-1:0] rd_cnt, rd_cnt_nxt;
  logic [WW-1:0] wd_cnt, wd_cnt_nxt;
  logic          core_wr_nxt;
  logic [7:0]    core_char_nxt;
  logic          core_start_nxt;
  logic [7:0]    out_char_nxt;
  logic [1:0]    out_valid_nxt;
  logic          out_last_nxt;
  logic          err_nxt;

  logic       g;
  logic [7:0] in_char_g;
  logic       accept;

  // Granted requester index and its data path; gnt is one-hot so bit 1 is the index.
  assign g         = gnt[1];
  assign in_char_g = g ? in_char1 : in_char0;
  assign accept    = (state == LOAD) && in_valid[g];
  assign in_ready  = (state == LOAD) ? gnt : 2'b00;
  assign busy      = (state != IDLE);

  // Next-state and next-output logic for the whole transaction sequence.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    last_srv_nxt   = last_srv;
    ld_cnt_nxt     = ld_cnt;
    rd_cnt_nxt     = rd_cnt;
    wd_cnt_nxt     = wd_cnt;
    core_wr_nxt    = 1'b0;
    core_char_nxt  = core_char;
    core_start_nxt = 1'b0;
    out_char_nxt   = out_char;
    out_valid_nxt  = 2'b00;
    out_last_nxt   = 1'b0;
    err_nxt        = 1'b0;

    case (state)
      IDLE: begin
        ld_cnt_nxt = '0;
        rd_cnt_nxt = '0;
        wd_cnt_nxt = '0;
        // On a tie the requester not served last wins.
        if (req == 2'b11) begin
          gnt_nxt = last_srv ? 2'b01 : 2'b10;
        end else if (req[0]) begin
          gnt_nxt = 2'b01;
        end else if (req[1]) begin
          gnt_nxt = 2'b10;
        end else begin
          gnt_nxt = 2'b00;
        end
        if (req != 2'b00) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end

      LOAD: begin
        if (accept) begin
          core_wr_nxt   = 1'b1;
          core_char_nxt = in_char_g;
          ld_cnt_nxt    = ld_cnt + LW'(1);
          if (ld_cnt == LAST_IDX) begin
            state_nxt = FLUSH;
          end else begin
            state_nxt = LOAD;
          end
        end else begin
          state_nxt = LOAD;
        end
      end

      // core_wr is still presenting the last character during this cycle.
      FLUSH: begin
        core_start_nxt = 1'b1;
        state_nxt      = START;
      end

      START: begin
        wd_cnt_nxt = '0;
        state_nxt  = WAIT;
      end

      WAIT, DRAIN: begin
        if (core_valid_in) begin
          out_char_nxt  = core_char_in;
          out_valid_nxt = gnt;
          rd_cnt_nxt    = rd_cnt + LW'(1);
          wd_cnt_nxt    = '0;
          if (rd_cnt == LAST_IDX) begin
            out_last_nxt = 1'b1;
            gnt_nxt      = 2'b00;
            last_srv_nxt = g;
            state_nxt    = IDLE;
          end else begin
            state_nxt = DRAIN;
          end
        end else if (wd_cnt == WD_LAST) begin
          // Abort on the edge where the silent-cycle count reaches TIMEOUT.
          err_nxt      = 1'b1;
          gnt_nxt      = 2'b00;
          last_srv_nxt = g;
          state_nxt    = IDLE;
        end else begin
          wd_cnt_nxt = wd_cnt + WW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      last_srv   <= 1'b1;
      ld_cnt     <= '0;
      rd_cnt     <= '0;
      wd_cnt     <= '0;
      core_wr    <= 1'b0;
      core_char  <= 8'h00;
      core_start <= 1'b0;
      out_char   <= 8'h00;
      out_valid  <= 2'b00;
      out_last   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_srv   <= last_srv_nxt;
      ld_cnt     <= ld_cnt_nxt;
      rd_cnt     <= rd_cnt_nxt;
      wd_cnt     <= wd_cnt_nxt;
      core_wr    <= core_wr_nxt;
      core_char  <= core_char_nxt;
      core_start <= core_start_nxt;
      out_char   <= out_char_nxt;
      out_valid  <= out_valid_nxt;
      out_last   <= out_last_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bwt_sched.sv
// Self-checking bench for bwt_sched: a table of transactions driven through
// one task, a negedge monitor with a return-character scoreboard, and a
// reset-mid-drain sequence folded into the same table.
module tb_bwt_sched;
  localparam int SL  = 8;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, gnt, in_valid, in_ready, out_valid;
  logic [7:0] in_char0, in_char1, core_char, core_char_in, out_char;
  logic       core_wr, core_start, core_valid_in, out_last, err, busy;
  logic [26:0] all_outs;

  bwt_sched #(.STRING_LEN(SL), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .in_valid(in_valid),
    .in_char0(in_char0), .in_char1(in_char1), .in_ready(in_ready),
    .core_wr(core_wr), .core_char(core_char), .core_start(core_start),
    .core_valid_in(core_valid_in), .core_char_in(core_char_in),
    .out_char(out_char), .out_valid(out_valid), .out_last(out_last),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign all_outs = {gnt, in_ready, core_wr, core_char, core_start, out_char,
                     out_valid, out_last, err, busy};

  typedef struct {
    logic [1:0]  rq;
    logic        g;
    logic        bp;
    logic        noise;
    int          lat;
    logic        tmo;
    int          rst_after;
    logic [63:0] str;
  } vec_t;

  typedef struct {
    logic [7:0] c;
    logic [1:0] v;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[11];
  int          n_err = 0;
  int          n_checks = 0;
  int          cyc_cnt = 0;
  int          wr_idx = 0;
  logic [63:0] cur_str = 64'h0;
  logic        mon_en = 1'b0;
  logic        prev_acc = 1'b0;
  logic        prev_wr = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] chr(input logic [63:0] s, input int i);
    return s[63-8*i -: 8];
  endfunction

  function automatic vec_t mk(input logic [1:0] rq, input logic g, input logic bp,
                              input logic noise, input int lat, input logic tmo,
                              input int rsta);
    vec_t v;
    v.rq = rq; v.g = g; v.bp = bp; v.noise = noise; v.lat = lat;
    v.tmo = tmo; v.rst_after = rsta;
    v.str = {$urandom(), $urandom()};
    return v;
  endfunction

  // Negedge monitor: load-side ordering, start placement, return scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (mon_en) begin
        check("in_ready_mask", {30'd0, in_ready & ~gnt}, 32'd0);
        check("core_wr_after_accept", {31'd0, core_wr}, {31'd0, prev_acc});
        if (core_wr) begin
          check("core_wr_count", (wr_idx < SL) ? 32'd1 : 32'd0, 32'd1);
          if (wr_idx < SL) check("core_char", {24'd0, core_char}, {24'd0, chr(cur_str, wr_idx)});
          wr_idx++;
        end
        if (core_start) begin
          check("start_after_last_wr", {31'd0, prev_wr}, 32'd1);
          check("start_wr_count", wr_idx, SL);
          check("start_no_wr", {31'd0, core_wr}, 32'd0);
        end
        if (out_valid != 2'b00) begin
          if (sb.size() == 0) begin
            check("out_spurious", {30'd0, out_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("out_char", {24'd0, out_char}, {24'd0, e.c});
            check("out_valid", {30'd0, out_valid}, {30'd0, e.v});
            check("out_last", {31'd0, out_last}, {31'd0, e.last});
            check("out_cycle", cyc_cnt, e.cyc);
          end
        end else begin
          check("out_last_without_valid", {31'd0, out_last}, 32'd0);
        end
        if (out_last) check("last_gnt_busy", {29'd0, gnt, busy}, 32'd0);
        if (err) check("err_gnt_busy_last", {28'd0, gnt, busy, out_last}, 32'd0);
      end
      prev_acc = |(in_valid & in_ready);
      prev_wr  = core_wr;
    end
  end

  task automatic run_txn(input vec_t v);
    logic [1:0] gv;
    int idx, cyc, k, n;
    logic vb, nb;
    gv = v.g ? 2'b10 : 2'b01;
    @(negedge clk);
    check("idle_before", {31'd0, busy}, 32'd0);
    cur_str = v.str;
    wr_idx  = 0;
    @(posedge clk); #1;
    req = v.rq;
    @(negedge clk);
    check("gnt_not_early", {30'd0, gnt}, 32'd0);
    @(negedge clk);
    check("gnt", {30'd0, gnt}, {30'd0, gv});
    check("busy_on_grant", {31'd0, busy}, 32'd1);
    check("in_ready_on_grant", {30'd0, in_ready}, {30'd0, gv});

    // Load phase: stream characters, optionally throttled or with noise.
    idx = 0;
    cyc = 0;
    while (idx < SL && cyc < 100) begin
      @(posedge clk); #1;
      if (v.noise && cyc == 0) req = 2'b00;
      vb = v.bp ? ~cyc[0] : 1'b1;
      nb = v.noise;
      in_valid = v.g ? {vb, nb} : {nb, vb};
      if (v.g) begin
        in_char1 = chr(v.str, idx);
        in_char0 = 8'($urandom_range(0, 255));
      end else begin
        in_char0 = chr(v.str, idx);
        in_char1 = 8'($urandom_range(0, 255));
      end
      core_valid_in = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      core_char_in  = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (in_valid[v.g] && in_ready[v.g]) idx++;
      cyc++;
    end
    check("load_done", idx, SL);
    @(posedge clk); #1;
    in_valid = 2'b00;
    core_valid_in = 1'b0;

    for (k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (core_start) break;
    end
    check("start_latency", k, 2);

    if (v.tmo) begin
      for (k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (err) break;
      end
      check("err_latency", k, TMO + 1);
      req = 2'b00;
      @(negedge clk);
      check("err_one_cycle", {31'd0, err}, 32'd0);
      check("idle_after_err", {29'd0, gnt, busy}, 32'd0);
    end else begin
      repeat (v.lat) begin
        @(posedge clk); #1;
      end
      n = (v.rst_after > 0) ? v.rst_after : SL;
      for (int i = 0; i < n; i++) begin
        @(posedge clk); #1;
        core_valid_in = 1'b1;
        core_char_in  = 8'($urandom_range(0, 255));
        sb.push_back('{c: core_char_in, v: gv, last: (i == SL - 1), cyc: cyc_cnt + 2});
      end
      @(posedge clk); #1;
      core_valid_in = 1'b0;
      @(negedge clk);
      if (v.rst_after > 0) begin
        #1 rst = 1'b0;
        #1 check("reset_mid_drain", {5'd0, all_outs}, 32'd0);
        req = 2'b00;
        repeat (2) begin
          @(negedge clk);
          check("reset_hold", {5'd0, all_outs}, 32'd0);
        end
        rst = 1'b1;
      end else begin
        check("out_last_cycle", {31'd0, out_last}, 32'd1);
        req = 2'b00;
        @(negedge clk);
        check("idle_gap", {29'd0, gnt, busy}, 32'd0);
      end
    end
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    check("load_count", wr_idx, SL);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, t=%0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0]  = mk(2'b11, 1'b0, 1'b0, 1'b0, 12, 1'b0, 0);
    vecs[0].str = "banana$x";
    vecs[1]  = mk(2'b11, 1'b1, 1'b0, 1'b0,  3, 1'b0, 0);
    vecs[2]  = mk(2'b11, 1'b0, 1'b1, 1'b0,  0, 1'b0, 0);
    vecs[3]  = mk(2'b01, 1'b0, 1'b0, 1'b1,  5, 1'b0, 0);
    vecs[4]  = mk(2'b01, 1'b0, 1'b0, 1'b0,  0, 1'b1, 0);
    vecs[5]  = mk(2'b11, 1'b1, 1'b0, 1'b0,  1, 1'b0, 0);
    vecs[6]  = mk(2'b10, 1'b1, 1'b1, 1'b0,  2, 1'b0, 0);
    vecs[7]  = mk(2'b01, 1'b0, 1'b0, 1'b0,  0, 1'b0, 0);
    vecs[8]  = mk(2'b10, 1'b1, 1'b0, 1'b0,  4, 1'b0, 3);
    vecs[9]  = mk(2'b11, 1'b0, 1'b0, 1'b0,  2, 1'b0, 0);
    vecs[10] = mk(2'b10, 1'b1, 1'b0, 1'b0,  1, 1'b0, 0);

    rst = 1'b0;
    req = 2'b00;
    in_valid = 2'b00;
    in_char0 = 8'h00;
    in_char1 = 8'h00;
    core_valid_in = 1'b0;
    core_char_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {5'd0, all_outs}, 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    for (int t = 0; t < 11; t++) run_txn(vecs[t]);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
